// File: rtl/reservation_station.sv
// Reservation station: holds issued ops, captures operands from the ALU/LSB CDBs and dispatches the lowest ready entry (RS_FAST_WAKEUP_EN: dispatch in the wakeup cycle).
// Latency: ready entry to ex_* in one cycle. Backpressure: none internally; full tells upstream to stall, rdy_in low freezes all state.
module reservation_station #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy_in,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic [5:0]           issue_openum,
    input  logic [31:0]          issue_V1,
    input  logic [31:0]          issue_V2,
    input  logic                 issue_Q1_valid,
    input  logic                 issue_Q2_valid,
    input  logic [ROB_TAG_W-1:0] issue_Q1,
    input  logic [ROB_TAG_W-1:0] issue_Q2,
    input  logic [31:0]          issue_imm,
    input  logic [31:0]          issue_pc,
    input  logic [ROB_TAG_W-1:0] issue_rob_id,
    input  logic                 cdb_alu_valid,
    input  logic [ROB_TAG_W-1:0] cdb_alu_rob_id,
    input  logic [31:0]          cdb_alu_result,
    input  logic                 cdb_lsb_valid,
    input  logic [ROB_TAG_W-1:0] cdb_lsb_rob_id,
    input  logic [31:0]          cdb_lsb_result,
    output logic                 full,
    output logic [5:0]           ex_openum,
    output logic [31:0]          ex_V1,
    output logic [31:0]          ex_V2,
    output logic [31:0]          ex_imm,
    output logic [31:0]          ex_pc,
    output logic [ROB_TAG_W-1:0] ex_rob_id
);
    localparam logic [5:0] OPENUM_NOP = 6'd0;
    localparam int         IDX_W      = $clog2(RS_SIZE);

    typedef struct packed {
        logic [5:0]           openum;
        logic [31:0]          v1;
        logic [31:0]          v2;
        logic [ROB_TAG_W-1:0] q1;
        logic [ROB_TAG_W-1:0] q2;
        logic                 q1_vld;
        logic                 q2_vld;
        logic [31:0]          imm;
        logic [31:0]          pc;
        logic [ROB_TAG_W-1:0] rob_id;
    } entry_t;

    entry_t             ent  [RS_SIZE];
    entry_t             woke [RS_SIZE];
    entry_t             cand [RS_SIZE];
    entry_t             issue_ent;
    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] ready;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   disp_idx;
    logic               disp_vld;
    logic               do_issue;

    // Returns {still_pending, value}; the ALU bus wins when both carry the tag.
    function automatic logic [32:0] capture(input logic pend, input logic [ROB_TAG_W-1:0] tag,
                                            input logic [31:0] val);
        if (pend && cdb_alu_valid && tag == cdb_alu_rob_id)
            return {1'b0, cdb_alu_result};
        else if (pend && cdb_lsb_valid && tag == cdb_lsb_rob_id)
            return {1'b0, cdb_lsb_result};
        else
            return {pend, val};
    endfunction

    always_comb begin
        issue_ent        = '0;
        issue_ent.openum = issue_openum;
        issue_ent.q1     = issue_Q1;
        issue_ent.q2     = issue_Q2;
        issue_ent.imm    = issue_imm;
        issue_ent.pc     = issue_pc;
        issue_ent.rob_id = issue_rob_id;
        {issue_ent.q1_vld, issue_ent.v1} = capture(issue_Q1_valid, issue_Q1, issue_V1);
        {issue_ent.q2_vld, issue_ent.v2} = capture(issue_Q2_valid, issue_Q2, issue_V2);
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            woke[i] = ent[i];
            if (busy[i]) begin
                {woke[i].q1_vld, woke[i].v1} = capture(ent[i].q1_vld, ent[i].q1, ent[i].v1);
                {woke[i].q2_vld, woke[i].v2} = capture(ent[i].q2_vld, ent[i].q2, ent[i].v2);
            end
        end
    end

    // Fast wakeup judges readiness on the post-capture view so the CDB value forwards straight out.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
`ifdef RS_FAST_WAKEUP_EN
            cand[i] = woke[i];
`else
            cand[i] = ent[i];
`endif
            ready[i] = busy[i] && !cand[i].q1_vld && !cand[i].q2_vld;
        end
    end

    always_comb begin
        free_idx = '0;
        disp_idx = '0;
        disp_vld = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IDX_W'(i);
            if (ready[i]) begin
                disp_idx = IDX_W'(i);
                disp_vld = 1'b1;
            end
        end
    end

    assign full     = &busy;
    assign do_issue = issue_valid && !full;

    // free_idx comes from the pre-dispatch busy vector, so a slot freed this cycle is never reused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= '0;
            for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
            ex_openum <= OPENUM_NOP;
            ex_V1     <= '0;
            ex_V2     <= '0;
            ex_imm    <= '0;
            ex_pc     <= '0;
            ex_rob_id <= '0;
        end else if (flush) begin
            busy      <= '0;
            ex_openum <= OPENUM_NOP;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) ent[i] <= woke[i];
            end
            if (disp_vld) begin
                busy[disp_idx] <= 1'b0;
                ex_openum      <= cand[disp_idx].openum;
                ex_V1          <= cand[disp_idx].v1;
                ex_V2          <= cand[disp_idx].v2;
                ex_imm         <= cand[disp_idx].imm;
                ex_pc          <= cand[disp_idx].pc;
                ex_rob_id      <= cand[disp_idx].rob_id;
            end else begin
                ex_openum <= OPENUM_NOP;
            end
            if (do_issue) begin
                busy[free_idx] <= 1'b1;
                ent[free_idx]  <= issue_ent;
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: slot-level reference model checked every cycle plus directed literal checks.
module tb_reservation_station;
    localparam int N = 16;
    localparam logic [5:0] NOP  = 6'd0;
    localparam logic [5:0] ADD  = 6'd1;
    localparam logic [5:0] ADDI = 6'd2;
    localparam logic [5:0] SUB  = 6'd3;
`ifdef RS_FAST_WAKEUP_EN
    localparam int EXTRA = 0;
`else
    localparam int EXTRA = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n, rdy_in, flush, issue_valid;
    logic [5:0]  issue_openum;
    logic [31:0] issue_V1, issue_V2, issue_imm, issue_pc;
    logic        issue_Q1_valid, issue_Q2_valid;
    logic [3:0]  issue_Q1, issue_Q2, issue_rob_id;
    logic        cdb_alu_valid, cdb_lsb_valid;
    logic [3:0]  cdb_alu_rob_id, cdb_lsb_rob_id;
    logic [31:0] cdb_alu_result, cdb_lsb_result;
    logic        full;
    logic [5:0]  ex_openum;
    logic [31:0] ex_V1, ex_V2, ex_imm, ex_pc;
    logic [3:0]  ex_rob_id;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    reservation_station #(.RS_SIZE(N), .ROB_TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .rdy_in(rdy_in), .flush(flush),
        .issue_valid(issue_valid), .issue_openum(issue_openum),
        .issue_V1(issue_V1), .issue_V2(issue_V2),
        .issue_Q1_valid(issue_Q1_valid), .issue_Q2_valid(issue_Q2_valid),
        .issue_Q1(issue_Q1), .issue_Q2(issue_Q2),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob_id(issue_rob_id),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob_id(cdb_alu_rob_id), .cdb_alu_result(cdb_alu_result),
        .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob_id(cdb_lsb_rob_id), .cdb_lsb_result(cdb_lsb_result),
        .full(full), .ex_openum(ex_openum), .ex_V1(ex_V1), .ex_V2(ex_V2),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rob_id(ex_rob_id)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: slots, each pending operand waits for its tag ----------------
    typedef struct {
        logic [5:0]  op;
        logic [31:0] v1, v2, imm, pc;
        int          q1, q2;
        bit          p1, p2;
        logic [3:0]  rob;
    } m_ent_t;

    m_ent_t      m_ent [N];
    bit          m_busy [N];
    logic [5:0]  e_op;
    logic [31:0] e_v1, e_v2, e_imm, e_pc;
    logic [3:0]  e_rob;

    task automatic resolve(input bit p, input int q, input logic [31:0] v,
                           output bit po, output logic [31:0] vo);
        po = p;
        vo = v;
        if (p && cdb_alu_valid && q == int'(cdb_alu_rob_id)) begin
            po = 1'b0;
            vo = cdb_alu_result;
        end else if (p && cdb_lsb_valid && q == int'(cdb_lsb_rob_id)) begin
            po = 1'b0;
            vo = cdb_lsb_result;
        end
    endtask

    function automatic int m_first_ready();
        for (int i = 0; i < N; i++)
            if (m_busy[i] && !m_ent[i].p1 && !m_ent[i].p2) return i;
        return -1;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < N; i++)
            if (!m_busy[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        bit          was_full;
        int          d, f;
        bit          np;
        logic [31:0] nv;
        was_full = m_full();
        f = -1;
        for (int i = N - 1; i >= 0; i--)
            if (!m_busy[i]) f = i;
        d = -1;
`ifndef RS_FAST_WAKEUP_EN
        d = m_first_ready();
`endif
        for (int i = 0; i < N; i++) begin
            if (m_busy[i]) begin
                resolve(m_ent[i].p1, m_ent[i].q1, m_ent[i].v1, np, nv);
                m_ent[i].p1 = np; m_ent[i].v1 = nv;
                resolve(m_ent[i].p2, m_ent[i].q2, m_ent[i].v2, np, nv);
                m_ent[i].p2 = np; m_ent[i].v2 = nv;
            end
        end
`ifdef RS_FAST_WAKEUP_EN
        d = m_first_ready();
`endif
        if (d >= 0) begin
            e_op  = m_ent[d].op;  e_v1 = m_ent[d].v1; e_v2  = m_ent[d].v2;
            e_imm = m_ent[d].imm; e_pc = m_ent[d].pc; e_rob = m_ent[d].rob;
            m_busy[d] = 1'b0;
        end else begin
            e_op = NOP;
        end
        if (issue_valid && !was_full) begin
            m_ent[f].op  = issue_openum;
            m_ent[f].imm = issue_imm;
            m_ent[f].pc  = issue_pc;
            m_ent[f].rob = issue_rob_id;
            m_ent[f].q1  = int'(issue_Q1);
            m_ent[f].q2  = int'(issue_Q2);
            resolve(issue_Q1_valid, int'(issue_Q1), issue_V1, np, nv);
            m_ent[f].p1 = np; m_ent[f].v1 = nv;
            resolve(issue_Q2_valid, int'(issue_Q2), issue_V2, np, nv);
            m_ent[f].p2 = np; m_ent[f].v2 = nv;
            m_busy[f] = 1'b1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
            e_op = NOP; e_v1 = '0; e_v2 = '0; e_imm = '0; e_pc = '0; e_rob = '0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
            e_op = NOP;
        end else if (rdy_in) begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_full", full, m_full());
            check("model_op", ex_openum, e_op);
            check("model_v1", ex_V1, e_v1);
            check("model_v2", ex_V2, e_v2);
            check("model_imm", ex_imm, e_imm);
            check("model_pc", ex_pc, e_pc);
            check("model_rob", ex_rob_id, e_rob);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        issue_valid = 1'b0; flush = 1'b0;
        cdb_alu_valid = 1'b0; cdb_lsb_valid = 1'b0;
    endtask

    task automatic put(input logic [5:0] op, input logic q1v, input logic [3:0] q1, input logic [31:0] v1,
                       input logic q2v, input logic [3:0] q2, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [3:0] rob);
        issue_valid = 1'b1; issue_openum = op;
        issue_Q1_valid = q1v; issue_Q1 = q1; issue_V1 = v1;
        issue_Q2_valid = q2v; issue_Q2 = q2; issue_V2 = v2;
        issue_imm = imm; issue_rob_id = rob; issue_pc = 32'h1000 + 32'(rob) * 4;
    endtask

    task automatic put_step(input logic [5:0] op, input logic q1v, input logic [3:0] q1, input logic [31:0] v1,
                            input logic q2v, input logic [3:0] q2, input logic [31:0] v2,
                            input logic [31:0] imm, input logic [3:0] rob);
        put(op, q1v, q1, v1, q2v, q2, v2, imm, rob);
        step();
        idle();
    endtask

    task automatic alu(input logic [3:0] tag, input logic [31:0] val);
        cdb_alu_valid = 1'b1; cdb_alu_rob_id = tag; cdb_alu_result = val;
    endtask

    task automatic lsb(input logic [3:0] tag, input logic [31:0] val);
        cdb_lsb_valid = 1'b1; cdb_lsb_rob_id = tag; cdb_lsb_result = val;
    endtask

    task automatic flush_step();
        flush = 1'b1;
        step();
        idle();
    endtask

    initial begin
        rst_n = 1'b0; rdy_in = 1'b1;
        put(NOP, 0, 0, 0, 0, 0, 0, 0, 0);
        cdb_alu_rob_id = '0; cdb_alu_result = '0; cdb_lsb_rob_id = '0; cdb_lsb_result = '0;
        idle();
        repeat (2) step();
        check("rst_full", full, 0);
        check("rst_op", ex_openum, NOP);
        check("rst_v1", ex_V1, 0);
        check("rst_rob", ex_rob_id, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        step();

        // ADDI with both operands ready
        put_step(ADDI, 0, 0, 32'd5, 0, 0, 32'd0, 32'd3, 4'd5);
        step();
        check("addi_op", ex_openum, ADDI);
        check("addi_v1", ex_V1, 5);
        check("addi_imm", ex_imm, 3);
        check("addi_rob", ex_rob_id, 5);
        step();
        check("addi_then_nop", ex_openum, NOP);

        // ADD waiting on tag 2, broadcast three cycles after issue
        flush_step();
        put_step(ADD, 1, 4'd2, 32'd0, 0, 0, 32'd7, 32'd0, 4'd6);
        step();
        step();
        alu(4'd2, 32'h10);
        step();
        idle();
        check("wake_op_cycle1", ex_openum, (EXTRA != 0) ? NOP : ADD);
        step();
        check("wake_op_cycle2", ex_openum, (EXTRA != 0) ? ADD : NOP);
        check("wake_v1", ex_V1, 32'h10);
        check("wake_rob", ex_rob_id, 6);

        // fill every slot, extra issue ignored, one wakeup frees one slot
        flush_step();
        for (int i = 0; i < N; i++) put_step(ADD, 1, 4'(i), 32'd0, 0, 0, 32'(i), 32'd0, 4'(i));
        check("fill_full", full, 1);
        put_step(SUB, 0, 0, 32'd1, 0, 0, 32'd1, 32'd0, 4'd15);
        check("overflow_full", full, 1);
        alu(4'd9, 32'h99);
        step();
        idle();
        repeat (EXTRA) step();
        check("fill_disp_op", ex_openum, ADD);
        check("fill_disp_rob", ex_rob_id, 9);
        check("fill_disp_v1", ex_V1, 32'h99);
        check("fill_not_full", full, 0);
        step();
        check("overflow_dropped", ex_openum, NOP);

        // slots 3 and 7 woken together: lower index first
        flush_step();
        for (int i = 0; i < 8; i++)
            put_step(ADD, 1, (i == 3 || i == 7) ? 4'd10 : 4'd11, 32'd0, 0, 0, 32'd0, 32'd0, 4'(i));
        alu(4'd10, 32'h33);
        step();
        idle();
        repeat (EXTRA) step();
        check("prio_first_rob", ex_rob_id, 3);
        check("prio_first_op", ex_openum, ADD);
        step();
        check("prio_second_rob", ex_rob_id, 7);
        step();
        check("prio_done", ex_openum, NOP);

        // operand captured on the issue cycle; ALU wins over LSB on the same tag
        flush_step();
        lsb(4'd12, 32'hABCD);
        put_step(ADD, 0, 0, 32'd1, 1, 4'd12, 32'd0, 32'd0, 4'd12);
        step();
        check("issue_cap_op", ex_openum, ADD);
        check("issue_cap_v2", ex_V2, 32'hABCD);
        alu(4'd13, 32'h1111);
        lsb(4'd13, 32'h2222);
        put_step(SUB, 1, 4'd13, 32'd0, 0, 0, 32'd5, 32'd0, 4'd13);
        step();
        check("alu_prio_op", ex_openum, SUB);
        check("alu_prio_v1", ex_V1, 32'h1111);

        // flush overrides a simultaneous issue
        flush_step();
        for (int i = 0; i < 5; i++) put_step(ADD, 1, 4'd14, 32'd0, 0, 0, 32'd0, 32'd0, 4'(i));
        put(ADDI, 0, 0, 32'd1, 0, 0, 32'd1, 32'd0, 4'd8);
        flush = 1'b1;
        step();
        idle();
        check("flush_full", full, 0);
        check("flush_op", ex_openum, NOP);
        alu(4'd14, 32'h44);
        step();
        idle();
        step();
        check("flush_no_disp", ex_openum, NOP);
        put_step(ADDI, 0, 0, 32'd2, 0, 0, 32'd0, 32'd9, 4'd8);
        step();
        check("post_flush_op", ex_openum, ADDI);
        check("post_flush_rob", ex_rob_id, 8);

        // rdy_in low freezes everything, but flush still applies
        put_step(ADD, 0, 0, 32'h77, 0, 0, 32'd0, 32'd0, 4'd3);
        rdy_in = 1'b0;
        put(ADD, 0, 0, 32'd1, 0, 0, 32'd1, 32'd0, 4'd9);
        step();
        step();
        idle();
        check("stall_op", ex_openum, NOP);
        check("stall_rob_hold", ex_rob_id, 8);
        rdy_in = 1'b1;
        step();
        check("unstall_op", ex_openum, ADD);
        check("unstall_rob", ex_rob_id, 3);
        step();
        check("stall_issue_dropped", ex_openum, NOP);
        put_step(ADD, 1, 4'd5, 32'd0, 0, 0, 32'd0, 32'd0, 4'd4);
        rdy_in = 1'b0;
        flush = 1'b1;
        step();
        idle();
        rdy_in = 1'b1;
        alu(4'd5, 32'h55);
        step();
        idle();
        step();
        check("stall_flush_honoured", ex_openum, NOP);

        // reset in the middle of a full station
        put_step(ADDI, 0, 0, 32'h55, 0, 0, 32'd0, 32'd0, 4'd2);
        for (int i = 0; i < N; i++) put_step(SUB, 1, 4'd6, 32'd0, 0, 0, 32'd0, 32'd0, 4'(i));
        check("pre_rst_full", full, 1);
        check("pre_rst_v1", ex_V1, 32'h55);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_full", full, 0);
        check("midrst_op", ex_openum, NOP);
        check("midrst_v1", ex_V1, 0);
        check("midrst_pc", ex_pc, 0);
        step();
        #2 rst_n = 1'b1;
        step();
        check("after_rst_full", full, 0);

        // mixed traffic on a small tag space, checked only against the model
        for (int c = 0; c < 400; c++) begin
            rdy_in         = ($urandom_range(0, 7) != 0);
            flush          = ($urandom_range(0, 59) == 0);
            issue_valid    = $urandom_range(0, 1);
            issue_openum   = 6'($urandom_range(1, 63));
            issue_Q1_valid = $urandom_range(0, 1);
            issue_Q2_valid = $urandom_range(0, 1);
            issue_Q1       = 4'($urandom_range(0, 3));
            issue_Q2       = 4'($urandom_range(0, 3));
            issue_V1       = $urandom;
            issue_V2       = $urandom;
            issue_imm      = $urandom;
            issue_pc       = $urandom;
            issue_rob_id   = 4'($urandom_range(0, 15));
            cdb_alu_valid  = ($urandom_range(0, 2) == 0);
            cdb_alu_rob_id = 4'($urandom_range(0, 3));
            cdb_alu_result = $urandom;
            cdb_lsb_valid  = ($urandom_range(0, 2) == 0);
            cdb_lsb_rob_id = 4'($urandom_range(0, 3));
            cdb_lsb_result = $urandom;
            step();
        end
        idle();
        rdy_in = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter RS_SIZE, default 16: number of entries; power of two, 4..32.
REQ-002 Parameter ROB_TAG_W, default 4: ROB index width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 rdy_in  input  1  global ready; when low, all state holds.
REQ-006 flush  input  1  misprediction rollback.
REQ-007 issue_valid  input  1  new instruction offered this cycle.
REQ-008 issue_openum  input  6  operation code; OPENUM_NOP never issued.
REQ-009 issue_V1 / issue_V2  input  32  operand values, meaningful when the matching Q valid is low.
REQ-010 issue_Q1_valid / issue_Q2_valid  input  1  operand still pending.
REQ-011 issue_Q1 / issue_Q2  input  ROB_TAG_W  producer tag of the pending operand.
REQ-012 issue_imm  input  32  immediate.
REQ-013 issue_pc  input  32  instruction address.
REQ-014 issue_rob_id  input  ROB_TAG_W  destination tag.
REQ-015 cdb_alu_valid, cdb_alu_rob_id, cdb_alu_result  input  1/ROB_TAG_W/32  ALU broadcast.
REQ-016 cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_result  input  1/ROB_TAG_W/32  load/store broadcast.
REQ-017 full  output  1  combinational; high when all entries are busy.
REQ-018 ex_openum  output  6  registered dispatched opcode; OPENUM_NOP when idle.
REQ-019 ex_V1, ex_V2, ex_imm, ex_pc  output  32  registered dispatched operands.
REQ-020 ex_rob_id  output  ROB_TAG_W  registered dispatched destination tag.

Function
REQ-021 Each entry holds busy, openum, V1, V2, Q1, Q2, Q1_valid, Q2_valid, imm, pc, rob_id.
REQ-022 An issue with issue_valid high and full low writes the lowest-index non-busy entry and sets its busy bit.
REQ-023 An issue while full is high is ignored; upstream is responsible for stalling.
REQ-024 Each cycle, every busy entry compares each pending Q against both CDB tags; on a match, it copies the result into V and clears Q_valid.
REQ-025 An issued operand whose Q matches a same-cycle CDB broadcast is captured as ready on write; the ALU CDB has priority if both CDBs carry the same tag.
REQ-026 An entry is ready when it is busy and both Q_valid bits are low.
REQ-027 Each cycle, the lowest-index ready entry is dispatched: its fields are registered onto the ex_* outputs and its busy bit is cleared; the dispatch latency is one cycle.
REQ-028 With no ready entry, ex_openum is registered as OPENUM_NOP and the other ex_* outputs hold.
REQ-029 An entry freed by dispatch is not reusable by an issue in the same cycle.
REQ-030 Issue and dispatch in the same cycle are both performed.
REQ-031 flush clears every busy bit and registers ex_openum to OPENUM_NOP; flush overrides issue and dispatch in that cycle.
REQ-032 While rdy_in is low, no issue, dispatch, or capture occurs; flush is still honoured.

Reset
REQ-033 rst_n low immediately clears all busy bits, sets ex_openum to OPENUM_NOP, and zeroes ex_V1, ex_V2, ex_imm, ex_pc, and ex_rob_id.
REQ-034 Reset asserted mid-operation discards all entries; full reads 0 while reset is held.

Configuration
REQ-035 Macro RS_FAST_WAKEUP_EN: when defined, the ready test also counts operands matched by the current cycle's CDB, so a woken entry dispatches in its wakeup cycle with the CDB value forwarded onto ex_V1/ex_V2.
REQ-036 When RS_FAST_WAKEUP_EN is undefined, a woken entry becomes eligible for dispatch one cycle after capture.

Verification
REQ-037 Issue ADDI with both operands ready, V1=5, imm=3 -> next cycle ex_openum=ADDI, ex_V1=5, ex_imm=3, ex_rob_id as issued; the following cycle ex_openum=NOP.
REQ-038 Issue ADD with Q1=2 pending, then cdb_alu_valid with rob_id=2 and result=0x10 three cycles later -> dispatch with ex_V1=0x10; dispatch occurs in the CDB cycle +1 with RS_FAST_WAKEUP_EN, or +2 without it.
REQ-039 Fill all 16 entries with pending operands -> full=1; a 17th issue is ignored; one CDB wakeup -> one dispatch, then full=0.
REQ-040 Two entries at indices 3 and 7 made ready simultaneously -> index 3 dispatched first and index 7 dispatched next cycle.
REQ-041 Issue with Q2 matching the same-cycle cdb_lsb tag (value 0xABCD) -> entry ready; ex_V2=0xABCD.
REQ-042 flush with 5 busy entries and issue_valid high -> next cycle full=0 and ex_openum=NOP, with no dispatch until a new issue.
